// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch prefetch stage.
package if_pkg;
    localparam int IF_BITSIZE  = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0]           instr;
        logic [IF_BITSIZE-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        STALL = 1'b1
    } if_state_e;
endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it in one edge.
module if_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  entry_t                 wdata_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output entry_t                 head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential prefetch into a small buffer, flushed and
// redirected on a taken branch. One memory request outstanding at a time.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int                 BITSIZE    = 32,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [BITSIZE-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               ID_IF_get_i,
    output logic               IF_ID_give_o,
    output logic [31:0]        IF_ID_instr_o,
    output logic [BITSIZE-1:0] IF_ID_pc_o,
    output logic [BITSIZE-1:0] MEM_addr_o,
    output logic               MEM_read_o,
    input  logic [31:0]        MEM_data_i,
    input  logic               MEM_valid_i,
    input  logic [BITSIZE-1:0] pc_i,
    input  logic               branch_taken_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]        instr;
        logic [BITSIZE-1:0] pc;
    } entry_t;

    if_state_e          state_q, state_d;
    logic [BITSIZE-1:0] fetch_pc_q, fetch_pc_d;
    entry_t             last_q, head, wdata;
    logic               push, pop, full, empty, read;
    logic [CW-1:0]      count;

    // Reset gates the request so it drops without waiting for an edge.
    assign read  = (state_q == FETCH) && !full && !branch_taken_i && !reset_i;
    assign push  = read && MEM_valid_i;
    assign pop   = IF_ID_give_o && ID_IF_get_i;
    assign wdata = '{instr: MEM_data_i, pc: fetch_pc_q};

    assign MEM_read_o    = read;
    assign MEM_addr_o    = fetch_pc_q;
    assign IF_ID_give_o  = !empty && !branch_taken_i;
    assign IF_ID_instr_o = empty ? last_q.instr : head.instr;
    assign IF_ID_pc_o    = empty ? last_q.pc    : head.pc;

    if_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (branch_taken_i),
        .wdata_i (wdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .head_o  (head)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (branch_taken_i) begin
            state_d    = FETCH;
            fetch_pc_d = pc_i & ~BITSIZE'(INSTR_BYTES - 1);
        end else begin
            case (state_q)
                FETCH: begin
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + BITSIZE'(INSTR_BYTES);
                        if (count == CW'(FIFO_DEPTH - 1) && !pop) state_d = STALL;
                    end
                end
                STALL: begin
                    if (pop) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            // Remember the head so the ID outputs hold steady once the buffer drains.
            if (!empty) last_q <= head;
        end
    end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench: memory model + reference buffer queue, checked by a negedge monitor.
module tb_if_prefetch_stage;
    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'hA5A5_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        get = 1'b0, br = 1'b0, mvalid = 1'b0;
    logic [31:0] mdata = '0, pci = '0;
    logic        give, read;
    logic [31:0] instr, pco, addr;

    logic        get2 = 1'b1;
    logic        give2, read2, mvalid2;
    logic [31:0] instr2, pco2, addr2, mdata2;

    if_prefetch_stage #(.BITSIZE(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset_i(rst), .ID_IF_get_i(get), .IF_ID_give_o(give),
        .IF_ID_instr_o(instr), .IF_ID_pc_o(pco), .MEM_addr_o(addr), .MEM_read_o(read),
        .MEM_data_i(mdata), .MEM_valid_i(mvalid), .pc_i(pci), .branch_taken_i(br)
    );

    // Second instance exercises address wrap from a high reset PC with a zero-wait memory.
    assign mvalid2 = read2;
    assign mdata2  = addr2 ^ K;
    if_prefetch_stage #(.BITSIZE(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC2)) u_dut2 (
        .clk(clk), .reset_i(rst), .ID_IF_get_i(get2), .IF_ID_give_o(give2),
        .IF_ID_instr_o(instr2), .IF_ID_pc_o(pco2), .MEM_addr_o(addr2), .MEM_read_o(read2),
        .MEM_data_i(mdata2), .MEM_valid_i(mvalid2), .pc_i(32'h0), .branch_taken_i(1'b0)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_addr = '0;
    int          mode = 0;
    int          waits = 0, wcnt = 0;
    bit          acc = 0, pop_l = 0;

    int          checks = 0, passed = 0, n2 = 0;
    logic [31:0] last_pc = '0, last_instr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Apply the previous cycle's effects to the reference buffer.
    task automatic commit();
        exp_t e;
        if (br) begin
            q.delete();
            exp_addr = {pci[31:2], 2'b00};
        end else begin
            if (pop_l) q.delete(0);
            if (acc) begin
                e.pc = exp_addr; e.instr = exp_addr ^ K;
                q.push_back(e);
                exp_addr = exp_addr + 32'd4;
            end
        end
    endtask

    task automatic step(input bit g, input bit b, input logic [31:0] t, input bit fv);
        @(posedge clk);
        commit();
        #1;
        get = g; br = b; pci = t;
        #1;
        if (read) begin
            if (wcnt >= waits) begin mvalid = 1'b1; mdata = addr ^ K; wcnt = 0; end
            else begin mvalid = 1'b0; wcnt++; end
        end else begin
            mvalid = 1'b0; wcnt = 0;
        end
        if (fv) begin mvalid = 1'b1; mdata = addr ^ K; end
        acc   = mvalid && !br && (q.size() < DEPTH);
        pop_l = get && !br && (q.size() != 0);
    endtask

    always @(negedge clk) begin
        if (mode == 2) begin
            chk("rst_read", {31'b0, read}, 32'd0);
            chk("rst_give", {31'b0, give}, 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_pc", pco, 32'd0);
            chk("rst_addr", addr, 32'd0);
            chk("rst2_addr", addr2, RPC2);
            chk("rst2_read", {31'b0, read2}, 32'd0);
            last_pc = '0; last_instr = '0;
        end else if (mode == 1) begin
            chk("mem_read", {31'b0, read}, {31'b0, !br && (q.size() < DEPTH)});
            chk("mem_addr", addr, exp_addr);
            chk("give", {31'b0, give}, {31'b0, !br && (q.size() != 0)});
            if (q.size() != 0) begin
                chk("head_pc", pco, q[0].pc);
                chk("head_instr", instr, q[0].instr);
                last_pc = q[0].pc; last_instr = q[0].instr;
            end else begin
                chk("held_pc", pco, last_pc);
                chk("held_instr", instr, last_instr);
            end
            if (!rst && n2 < 4 && give2) begin
                chk("wrap_pc", pco2, RPC2 + 32'(n2 * 4));
                chk("wrap_instr", instr2, (RPC2 + 32'(n2 * 4)) ^ K);
                n2++;
            end
        end else if (mode == 3) begin
            chk("wrap_delivered", n2, 32'd4);
            $display("%0d/%0d checks passed", passed, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1; mode = 2;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0; exp_addr = 32'h0; mode = 1;

        // Streaming with zero-wait memory and a consumer that always takes.
        waits = 0;
        repeat (20) step(1, 0, 0, 0);

        // Consumer stalls: buffer fills, reads stop, one pop restarts fetch.
        step(0, 1, 32'h0, 0);
        repeat (8) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0);

        // Three-cycle memory latency.
        waits = 2;
        repeat (30) step(1, 0, 0, 0);

        // Branch while data for pc 12 is returning; that data must be dropped.
        waits = 0;
        step(0, 1, 32'h0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h100, 1);
        repeat (10) step(1, 0, 0, 0);

        // Misaligned target, back-to-back branches, and wrap past the top of memory.
        step(1, 1, 32'h203, 0);
        repeat (5) step(1, 0, 0, 0);
        step(1, 1, 32'h500, 0);
        step(1, 1, 32'h600, 0);
        repeat (4) step(1, 0, 0, 0);
        step(1, 1, 32'hFFFF_FFF4, 0);
        repeat (8) step(1, 0, 0, 0);

        // Randomized traffic across latencies.
        for (int c = 0; c < 8; c++) begin
            waits = $urandom_range(3);
            for (int i = 0; i < 50; i++)
                step($urandom_range(99) < 60, $urandom_range(99) < 5, $urandom, 0);
        end

        // Reset in the middle of a request with two entries buffered.
        waits = 0;
        step(0, 1, 32'h40, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(posedge clk);
        commit();
        #2 rst = 1'b1; mode = 2;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0; q.delete(); exp_addr = 32'h0;
        br = 1'b0; get = 1'b0; mvalid = 1'b0; acc = 0; pop_l = 0; wcnt = 0;
        mode = 1;
        repeat (12) step(1, 0, 0, 0);

        @(posedge clk);
        #1 mode = 3;
    end
endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage that prefetches sequential instructions into a FIFO_DEPTH-entry buffer, so decode can consume one instruction per cycle while memory latency is hidden. It sits between the instruction memory port and the ID stage. On a taken branch it flushes the buffer and redirects fetch to the branch target.

Parameters:
BITSIZE, 32, width of the PC and fetch address.
FIFO_DEPTH, 4, prefetch buffer entries; power of two, at least 2.
RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_i  in  1  asynchronous, active-high reset.
ID_IF_get_i  in  1  ID is ready to accept an instruction.
IF_ID_give_o  out  1  buffer head is valid.
IF_ID_instr_o  out  32  instruction at the buffer head.
IF_ID_pc_o  out  BITSIZE  PC of the buffer-head instruction.
MEM_addr_o  out  BITSIZE  fetch address.
MEM_read_o  out  1  fetch request.
MEM_data_i  in  32  fetch data.
MEM_valid_i  in  1  fetch data valid.
pc_i  in  BITSIZE  branch target.
branch_taken_i  in  1  redirect and flush.

Behaviour:
- Reset (async, active-high):
  - State = FETCH; fetch_pc = RESET_PC; FIFO count = 0; read/write pointers = 0.
  - Outputs during reset: IF_ID_give_o=0, MEM_read_o=0, IF_ID_instr_o=0, IF_ID_pc_o=0.
  - MEM_addr_o = RESET_PC.
- Memory protocol:
  - MEM_read_o asserts with MEM_addr_o = fetch_pc.
  - Address and read stay stable until MEM_valid_i is seen or a branch occurs.
  - MEM_valid_i may arrive in the same cycle as MEM_read_o (zero wait states) or any later cycle.
  - At most one request is outstanding.
  - MEM_valid_i is ignored when MEM_read_o=0.
- FSM states:
  - FETCH: MEM_read_o=1.
    - On MEM_valid_i: push {MEM_data_i, fetch_pc}; fetch_pc <= fetch_pc+4.
    - If that push makes the FIFO full and there is no pop this cycle, go to STALL.
  - STALL: MEM_read_o=0.
    - Return to FETCH in the cycle after any pop.
    - Read is never issued while full, so MEM_read_o has no combinational path from ID_IF_get_i.
- Fetch count per request: the PC increments once per accepted response, modulo 2^BITSIZE (0xFFFFFFFC+4 wraps to 0).
- ID handshake:
  - IF_ID_give_o = (count != 0) and not branch_taken_i.
  - Outputs show the head entry; when the FIFO is empty, instr and pc are held at their last value (0 after reset).
  - Transfer occurs when IF_ID_give_o && ID_IF_get_i, and pops the head.
  - Push and pop in the same cycle leave count unchanged.
  - Empty-buffer latency: data returned in cycle N is visible on IF_ID_* in cycle N+1.
  - Sustained throughput is 1 instruction/cycle with zero-wait memory.
- Branch (branch_taken_i=1), which has priority over everything else:
  - Same cycle: MEM_read_o=0, IF_ID_give_o=0, and any MEM_valid_i or get_i is ignored (the outstanding request is abandoned; memory must tolerate a dropped read).
  - Next edge: FIFO flushed (count=0, pointers reset), fetch_pc <= {pc_i[BITSIZE-1:2], 2'b00}, state = FETCH.
  - A first request to the target issues in the following cycle.
  - Back-to-back branches: the last target wins.
- Reset asserted mid-request: the request is dropped immediately and MEM_read_o drops asynchronously.

Decomposition:
- Package if_pkg:
  - typedef fetch_entry_t {logic [31:0] instr; logic [BITSIZE-1:0] pc;}
  - FSM enum if_state_e {FETCH, STALL}
  - constant INSTR_BYTES = 4.
- Sub-module if_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Async reset.
  - The FSM and PC logic live in if_prefetch_stage.

Test Plan:
- Reset release, zero-wait memory returning instr = addr ^ 0xA5A5_0000, get_i=1 constant -> addresses 0,4,8,… issued every cycle; IF_ID_pc_o = 0,4,8 one cycle later, with matching instructions.
- get_i=0, zero-wait memory -> exactly 4 pushes (pc 0..12); give=1; MEM_read_o=0 from the 5th cycle; then one get pulse -> pops pc=0, and read resumes at addr 16 the next cycle.
- Memory latency 3 cycles, get_i=1 -> MEM_addr_o held stable 3 cycles per request; one instruction delivered every 3 cycles; no duplicates or gaps.
- FIFO holding pc 0,4,8, branch_taken_i=1 with pc_i=0x100 while a request to 12 is in flight and MEM_valid_i=1 -> give=0 and read=0 that cycle; the data for 12 is discarded; next delivered instruction has pc=0x100.
- pc_i=0x203 -> fetch resumes at 0x200.
- RESET_PC=0xFFFF_FFF8 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 in order.
- Assert reset_i between clock edges while MEM_read_o=1 and count=2 -> MEM_read_o and give drop before the next edge; after release, fetch restarts at RESET_PC.
